// File: rtl/eth_rx_pkg.sv
// Shared types, wire constants and the byte-wise CRC-32 step for the Ethernet II receiver.
package eth_rx_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DST,
    S_SRC,
    S_LEN,
    S_PL,
    S_FCS,
    S_CHK,
    S_DROP,
    S_ABORT
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PREAMBLE_LEN  = 7;
  localparam int          MAC_LEN       = 6;
  localparam int          FCS_LEN       = 4;
  localparam logic [47:0] BCAST_ADDR    = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  // Reflected CRC-32: the byte enters LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// CRC-32 accumulator: one byte per enable, reloads the init value on clear.
module eth_crc32
  import eth_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data_in,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC_INIT;
    end else if (enable) begin
      crc_d = crc32_byte(crc_q, data_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/eth_frame_rx.sv
// Ethernet II byte-stream receiver: preamble/SFD check, DST filter, length bounds, payload stream, FCS check.
// Define ETH_RX_BCAST_EN to also accept the broadcast destination address.
module eth_frame_rx
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] DEST_MAC_ADDR = 48'h00_0a_95_9d_68_16,
  parameter logic [15:0] MIN_PL        = 16'd46,
  parameter logic [15:0] MAX_PL        = 16'd1500,
  parameter int          GAP_TIMEOUT   = 8,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_vld,
  input  logic             start,
  output logic             ready,
  output logic [7:0]       out_data,
  output logic             out_vld,
  output logic             out_last,
  output logic             frm_done,
  output logic             frm_ok,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int               GAP_W    = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
  localparam logic [15:0]      PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0]      MAC_LAST = 16'(MAC_LEN - 1);
  localparam logic [15:0]      FCS_LAST = 16'(FCS_LEN - 1);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       len_q, len_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_vld_q, out_vld_d;
  logic              out_last_q, out_last_d;
  logic [CNT_W-1:0]  ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
`ifdef ETH_RX_BCAST_EN
  logic              bcast_q, bcast_d;
`endif

  logic              crc_clear, crc_en;
  logic [31:0]       crc;
  logic              in_frame, gap_expired, dst_match;
  logic [7:0]        dst_byte;
  logic [15:0]       len_full;

  eth_crc32 u_crc (
    .clk     (clk),
    .rst     (rst),
    .clear   (crc_clear),
    .enable  (crc_en),
    .data_in (in_data),
    .crc     (crc)
  );

  assign in_frame    = state_q inside {S_PRE, S_SFD, S_DST, S_SRC, S_LEN, S_PL, S_FCS};
  assign gap_expired = in_frame && !in_vld && (gap_q == GAP_LAST);
  assign dst_byte    = 8'(DEST_MAC_ADDR >> (8 * (MAC_LEN - 1 - int'(cnt_q[2:0]))));
  assign len_full    = {len_q[15:8], in_data};

  // A broadcast byte only counts while every earlier DST byte was also 8'hFF.
`ifdef ETH_RX_BCAST_EN
  assign dst_match = (in_data == dst_byte) || (bcast_q && (in_data == BCAST_ADDR[7:0]));
`else
  assign dst_match = (in_data == dst_byte);
`endif

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    gap_d      = '0;
    out_data_d = out_data_q;
    out_vld_d  = 1'b0;
    out_last_d = 1'b0;
    ok_cnt_d   = ok_cnt_q;
    err_cnt_d  = err_cnt_q;
    crc_clear  = (state_q == S_IDLE);
    crc_en     = 1'b0;
    frm_done   = 1'b0;
    frm_ok     = 1'b0;
`ifdef ETH_RX_BCAST_EN
    bcast_d    = bcast_q;
`endif

    if (in_frame && !in_vld) begin
      gap_d = gap_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && in_vld && (in_data == PREAMBLE_BYTE)) begin
          state_d = S_PRE;
          cnt_d   = 16'd1;
        end
      end
      S_PRE: begin
        if (in_vld) begin
          if (in_data != PREAMBLE_BYTE) begin
            state_d = S_DROP;
          end else if (cnt_q == PRE_LAST) begin
            state_d = S_SFD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_SFD: begin
        if (in_vld) begin
          state_d = (in_data == SFD_BYTE) ? S_DST : S_DROP;
          cnt_d   = '0;
`ifdef ETH_RX_BCAST_EN
          bcast_d = 1'b1;
`endif
        end
      end
      S_DST: begin
        if (in_vld) begin
          crc_en = 1'b1;
`ifdef ETH_RX_BCAST_EN
          bcast_d = bcast_q && (in_data == BCAST_ADDR[7:0]);
`endif
          if (!dst_match) begin
            state_d = S_DROP;
          end else if (cnt_q == MAC_LAST) begin
            state_d = S_SRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_SRC: begin
        if (in_vld) begin
          crc_en = 1'b1;
          if (cnt_q == MAC_LAST) begin
            state_d = S_LEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_LEN: begin
        if (in_vld) begin
          crc_en = 1'b1;
          if (cnt_q == 16'd0) begin
            len_d[15:8] = in_data;
            cnt_d       = 16'd1;
          end else begin
            len_d   = len_full;
            cnt_d   = '0;
            state_d = ((len_full < MIN_PL) || (len_full > MAX_PL)) ? S_ABORT : S_PL;
          end
        end
      end
      S_PL: begin
        if (in_vld) begin
          crc_en     = 1'b1;
          out_vld_d  = 1'b1;
          out_data_d = in_data;
          if (cnt_q == len_q - 16'd1) begin
            out_last_d = 1'b1;
            state_d    = S_FCS;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_FCS: begin
        if (in_vld) begin
          crc_en = 1'b1;
          if (cnt_q == FCS_LAST) begin
            state_d = S_CHK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_CHK: begin
        frm_done = 1'b1;
        frm_ok   = (crc == CRC_RESIDUE);
        if (frm_ok) begin
          if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + 1'b1;
        end else begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      S_ABORT: begin
        frm_done = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        state_d = S_IDLE;
      end
      S_DROP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A stalled stream overrides whatever the byte decode chose.
    if (gap_expired) begin
      state_d = S_ABORT;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
`ifdef ETH_RX_BCAST_EN
      bcast_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
`ifdef ETH_RX_BCAST_EN
      bcast_q    <= bcast_d;
`endif
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign out_data = out_data_q;
  assign out_vld  = out_vld_q;
  assign out_last = out_last_q;
  assign ok_cnt   = ok_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule
